// File: rtl/jtag_scan_master.sv
// JTAG master: divides CLK into TCK, walks the TAP through reset, IR/DR scans
// and Run-Test/Idle waits, and returns the captured TDO bits per command.
module jtag_scan_master #(
   parameter int DIV = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [1:0]  CMD_OP,
   input  logic [5:0]  CMD_LEN,
   input  logic [31:0] CMD_DATA,
   output logic        RSP_VALID,
   output logic [31:0] RSP_DATA,
   output logic        BUSY,
   output logic        TCK,
   output logic        TMS,
   output logic        TDI,
   input  logic        TDO,
   output logic        TRSTN
);

   localparam int PW = $clog2(2 * DIV) + 1;
   localparam logic [PW-1:0] PH_RISE = PW'(DIV - 1);
   localparam logic [PW-1:0] PH_HI   = PW'(DIV);
   localparam logic [PW-1:0] PH_LAST = PW'(2 * DIV - 1);

   typedef enum logic [2:0] {
      S_AUTO_TLR, S_IDLE, S_HDR, S_SHIFT, S_TRAIL, S_WAIT, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ph_q, ph_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [1:0]    op_q, op_d;
   logic [5:0]    len_q, len_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   cap_q, cap_d;
   logic [31:0]   rsp_q, rsp_d;
   logic          cmd_q, cmd_d;
   logic          trstn_q, trstn_d;

   logic          idle_like;
   logic          in_bit;
   logic [5:0]    seg_last;
   logic [5:0]    len_eff;

   assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
   assign in_bit    = !idle_like;
   assign len_eff   = ((CMD_LEN == 6'd0) || (CMD_LEN > 6'd32)) ? 6'd32 : CMD_LEN;

   always_comb begin
      case (state_q)
         S_AUTO_TLR: seg_last = 6'd5;
         S_HDR:      seg_last = (op_q == 2'b01) ? 6'd3 : 6'd2;
         S_SHIFT:    seg_last = len_q - 6'd1;
         S_TRAIL:    seg_last = 6'd1;
         S_WAIT:     seg_last = len_q - 6'd1;
         default:    seg_last = 6'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      len_d   = len_q;
      data_d  = data_q;
      cap_d   = cap_q;
      rsp_d   = rsp_q;
      cmd_d   = cmd_q;
      trstn_d = 1'b1;

      if (idle_like) begin
         state_d = S_IDLE;
         if (CMD_VALID) begin
            op_d   = CMD_OP;
            data_d = CMD_DATA;
            cap_d  = '0;
            ph_d   = '0;
            cnt_d  = '0;
            len_d  = (CMD_OP[1] ^ CMD_OP[0]) ? len_eff : CMD_LEN;
            case (CMD_OP)
               2'b00: begin
                  state_d = S_AUTO_TLR;
                  cmd_d   = 1'b1;
               end
               2'b01, 2'b10: state_d = S_HDR;
               default: begin
                  // A zero-length wait completes without any TCK activity
                  if (CMD_LEN == 6'd0) begin
                     state_d = S_DONE;
                     rsp_d   = '0;
                  end else begin
                     state_d = S_WAIT;
                  end
               end
            endcase
         end
      end else begin
         // TDO is captured on the CLK edge that raises TCK
         if ((state_q == S_SHIFT) && (ph_q == PH_RISE)) begin
            cap_d[cnt_q[4:0]] = TDO;
         end
         if (ph_q == PH_LAST) begin
            ph_d  = '0;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == seg_last) begin
               cnt_d = '0;
               case (state_q)
                  S_AUTO_TLR: begin
                     state_d = cmd_q ? S_DONE : S_IDLE;
                     rsp_d   = cmd_q ? 32'd0 : rsp_q;
                     cmd_d   = 1'b0;
                  end
                  S_HDR:   state_d = S_SHIFT;
                  S_SHIFT: state_d = S_TRAIL;
                  S_TRAIL: begin
                     state_d = S_DONE;
                     rsp_d   = cap_q;
                  end
                  default: begin
                     state_d = S_DONE;
                     rsp_d   = '0;
                  end
               endcase
            end
         end else begin
            ph_d = ph_q + PW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_AUTO_TLR;
         ph_q    <= '0;
         cnt_q   <= '0;
         rsp_q   <= '0;
         cmd_q   <= 1'b0;
         trstn_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         rsp_q   <= rsp_d;
         cmd_q   <= cmd_d;
         trstn_q <= trstn_d;
      end
   end

   always_ff @(posedge CLK) begin
      op_q   <= op_d;
      len_q  <= len_d;
      data_q <= data_d;
      cap_q  <= cap_d;
   end

   // Pin values are decoded from the bit position, so TMS/TDI change with TCK falling
   always_comb begin
      case (state_q)
         S_AUTO_TLR: TMS = (cnt_q < 6'd5);
         S_HDR:      TMS = (cnt_q < ((op_q == 2'b01) ? 6'd2 : 6'd1));
         S_SHIFT:    TMS = (cnt_q == len_q - 6'd1);
         S_TRAIL:    TMS = (cnt_q == 6'd0);
         default:    TMS = 1'b0;
      endcase
   end

   assign TCK       = in_bit && (ph_q >= PH_HI);
   assign TDI       = (state_q == S_SHIFT) && data_q[cnt_q[4:0]];
   assign CMD_READY = idle_like;
   assign BUSY      = !idle_like;
   assign RSP_VALID = (state_q == S_DONE);
   assign RSP_DATA  = rsp_q;
   assign TRSTN     = trstn_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: behavioural TAP target plus a scoreboard that
// predicts each response, its latency and TCK count from the command alone.
module tb_jtag_scan_master;

   localparam int DIV = 2;
   localparam logic [3:0] IR_CAP = 4'b0001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = '0;
   logic [5:0]  cmd_len = '0;
   logic [31:0] cmd_data = '0;
   logic        tdo = 1'b0;
   logic        cmd_ready, rsp_valid, busy, tck, tms, tdi, trstn;
   logic [31:0] rsp_data;

   jtag_scan_master #(.DIV(DIV)) dut (
      .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
      .CMD_OP(cmd_op), .CMD_LEN(cmd_len), .CMD_DATA(cmd_data),
      .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .BUSY(busy),
      .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo), .TRSTN(trstn)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural TAP target ----------------
   typedef enum logic [3:0] {
      TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
      SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR
   } tap_t;

   function automatic tap_t tap_next(input tap_t s, input logic m);
      case (s)
         TLR:   return m ? TLR   : RTI;
         RTI:   return m ? SELDR : RTI;
         SELDR: return m ? SELIR : CAPDR;
         CAPDR: return m ? EX1DR : SHDR;
         SHDR:  return m ? EX1DR : SHDR;
         EX1DR: return m ? UPDR  : PAUDR;
         PAUDR: return m ? EX2DR : PAUDR;
         EX2DR: return m ? UPDR  : SHDR;
         UPDR:  return m ? SELDR : RTI;
         SELIR: return m ? TLR   : CAPIR;
         CAPIR: return m ? EX1IR : SHIR;
         SHIR:  return m ? EX1IR : SHIR;
         EX1IR: return m ? UPIR  : PAUIR;
         PAUIR: return m ? EX2IR : PAUIR;
         EX2IR: return m ? UPIR  : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   tap_t        tap_st = TLR;
   logic [3:0]  ir_sr = '0;
   logic        byp = 1'b0;
   int          tck_cnt = 0;
   logic [15:0] tms_hist = '0;
   logic [15:0] tdi_hist = '0;

   always @(posedge tck or negedge trstn) begin
      if (!trstn) begin
         tap_st <= TLR;
      end else begin
         tck_cnt  <= tck_cnt + 1;
         tms_hist <= {tms_hist[14:0], tms};
         tdi_hist <= {tdi_hist[14:0], tdi};
         case (tap_st)
            CAPIR: ir_sr <= IR_CAP;
            SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
            CAPDR: byp <= 1'b0;
            SHDR:  byp <= tdi;
            default: ;
         endcase
         tap_st <= tap_next(tap_st, tms);
      end
   end

   always @(negedge tck) begin
      tdo = (tap_st == SHIR) ? ir_sr[0] : ((tap_st == SHDR) ? byp : 1'b0);
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      logic [31:0] rsp;
      int          ntck;
      int          lat;
      int          acc_cyc;
      int          tck0;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   last_acc = 0;

   // IR is 4 bits capturing IR_CAP; every DR scan goes through the 1-bit bypass
   function automatic void predict(input logic [1:0] op, input logic [5:0] len,
                                   input logic [31:0] data,
                                   output logic [31:0] rsp, output int nbits);
      int l;
      l = (len == 0 || len > 32) ? 32 : int'(len);
      rsp = '0;
      case (op)
         2'b00: nbits = 6;
         2'b01: begin
            for (int i = 0; i < l; i++) rsp[i] = (i < 4) ? IR_CAP[i] : data[i-4];
            nbits = l + 6;
         end
         2'b10: begin
            for (int i = 1; i < l; i++) rsp[i] = data[i-1];
            nbits = l + 5;
         end
         default: nbits = int'(len);
      endcase
   endfunction

   task automatic issue(input logic [1:0] op, input logic [5:0] len,
                        input logic [31:0] data, input string nm);
      exp_t e;
      int   n;
      int   nb;
      @(negedge clk);
      cmd_op    = op;
      cmd_len   = len;
      cmd_data  = data;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      predict(op, len, data, e.rsp, nb);
      e.ntck    = nb;
      e.lat     = nb * 2 * DIV + 1;
      e.acc_cyc = cyc;
      e.tck0    = tck_cnt;
      e.name    = nm;
      sbq.push_back(e);
      last_acc = cyc;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (busy) chk("ready_while_busy", {63'd0, cmd_ready}, 64'd0);
         if (rsp_valid) begin
            if (sbq.size() == 0) begin
               chk("spurious_rsp", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk({e.name, "_rsp"},  {32'd0, rsp_data}, {32'd0, e.rsp});
               chk({e.name, "_lat"},  64'(cyc - e.acc_cyc), 64'(e.lat));
               chk({e.name, "_ntck"}, 64'(tck_cnt - e.tck0), 64'(e.ntck));
               chk({e.name, "_tap_rti"}, {63'd0, tap_st == RTI}, 64'd1);
            end
         end
      end
   end

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         chk({nm, "_drain_timeout"}, 64'(sbq.size()), 64'd0);
         sbq.delete();
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_pins"},
          {57'd0, tck, tms, tdi, trstn, cmd_ready, rsp_valid, busy},
          64'b0100001);
      chk({nm, "_rsp_data"}, {32'd0, rsp_data}, 64'd0);
   endtask

   task automatic startup(input string nm);
      int c0;
      int t0;
      int n;
      @(negedge clk);
      rst = 1'b1;
      sbq.delete();
      repeat (3) @(negedge clk);
      chk_reset_vals({nm, "_reset"});
      rst = 1'b0;
      c0 = cyc;
      t0 = tck_cnt;
      chk({nm, "_trstn_low"}, {63'd0, trstn}, 64'd0);
      @(negedge clk);
      chk({nm, "_trstn_high"}, {63'd0, trstn}, 64'd1);
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_ready_cycle"}, 64'(cyc - c0), 64'd24);
      chk({nm, "_tck_pulses"}, 64'(tck_cnt - t0), 64'd6);
      chk({nm, "_tms_seq"}, {58'd0, tms_hist[5:0]}, 64'b111110);
      chk({nm, "_tap_rti"}, {63'd0, tap_st == RTI}, 64'd1);
   endtask

   initial begin
      int a;
      logic [1:0]  op;
      logic [5:0]  len;

      startup("start");

      issue(2'b01, 6'd4, 32'h9, "ir4");
      drain("ir4");
      chk("ir4_tms_seq", {54'd0, tms_hist[9:0]}, 64'b1100000110);
      chk("ir4_tdi_seq", {54'd0, tdi_hist[9:0]}, 64'b0000100100);
      chk("ir4_const", {32'd0, rsp_data}, 64'h1);

      issue(2'b10, 6'd0, 32'hDEADBEEF, "dr32_byp");
      drain("dr32_byp");
      chk("dr32_const", {32'd0, rsp_data}, 64'hBD5B7DDE);

      issue(2'b10, 6'd8, $urandom, "dr8");
      a = last_acc;
      issue(2'b11, 6'd3, 32'h0, "b2b_rti3");
      chk("b2b_accept_cycle", 64'(last_acc - a), 64'd53);
      drain("b2b");

      issue(2'b11, 6'd0, 32'hFFFF_FFFF, "rti0");
      issue(2'b11, 6'd5, 32'h0, "rti5");
      issue(2'b00, 6'd0, 32'h0, "tlr");
      drain("rti");

      for (int k = 0; k < 25; k++) begin
         op  = 2'($urandom_range(0, 3));
         len = (op == 2'b11) ? 6'($urandom_range(0, 12)) : 6'($urandom_range(0, 63));
         issue(op, len, $urandom, $sformatf("rnd%0d", k));
      end
      drain("rnd");

      issue(2'b10, 6'd20, $urandom, "dr20_abort");
      repeat (30) @(negedge clk);
      rst = 1'b1;
      sbq.delete();
      @(negedge clk);
      chk_reset_vals("midscan");
      startup("restart");
      issue(2'b01, 6'd8, $urandom, "ir8_after");
      drain("ir8_after");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/jtag_scan_master.md
# jtag_scan_master

Clock-synchronous JTAG master that sequences the MCU debug TAP (TCK/TMS/TDI/TDO/TRST) from a simple command interface. It drives the board-level JTAG pins of `mcu_top` on the bench, or from a future on-chip debug bridge. Each command is one of: TAP reset, IR scan, DR scan or Run-Test/Idle wait. The block generates TCK by dividing CLK and walks the TAP state machine itself. It returns the captured TDO bits as one response per command.

## Interface

Parameters:
- DIV, 2: TCK half-period in CLK cycles, ≥1. One TCK bit = 2*DIV CLK cycles.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous reset, active-high.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  block can accept a command.
- CMD_OP  in  2  00 TAP reset, 01 IR scan, 10 DR scan, 11 RTI wait.
- CMD_LEN  in  6  scan length in bits, or RTI wait in TCK cycles.
- CMD_DATA  in  32  TDI shift data, LSB first.
- RSP_VALID  out  1  single-cycle pulse: command complete.
- RSP_DATA  out  32  captured TDO, LSB = first shifted bit.
- BUSY  out  1  high whenever not in IDLE.
- TCK  out  1  JTAG clock.
- TMS  out  1  JTAG mode select.
- TDI  out  1  JTAG data to target.
- TDO  in  1  JTAG data from target.
- TRSTN  out  1  JTAG reset, active-low.

## Operation

- **Reset values (RST high):** TCK 0, TMS 1, TDI 0, TRSTN 0, CMD_READY 0, RSP_VALID 0, RSP_DATA 0, BUSY 1.
- **RST mid-command:** the command is dropped and no RSP_VALID is issued.
- **TRSTN:** registered; goes to 1 in the first cycle after RST deasserts.
- **FSM states:** AUTO_TLR, IDLE, HDR, SHIFT, TRAIL, WAIT, DONE.
- **After RST deasserts:** AUTO_TLR drives 6 TCK bits with TMS = 1,1,1,1,1,0, leaving the TAP in RTI. Then go to IDLE. No RSP_VALID is issued.
- **IDLE:** CMD_READY=1, BUSY=0.
- **Accept:** on the CLK edge where CMD_VALID && CMD_READY. OP, LEN and DATA are latched. CMD_READY drops the next cycle. Inputs are ignored while busy.
- **Every op starts and ends in RTI.**
- **TAP reset (00):** 6 bits, TMS 1,1,1,1,1,0.
- **IR scan (01):** header TMS 1,1,0,0; then L shift bits with TMS 0 except the last = 1; then trailer TMS 1,0. Total L+6 bits.
- **DR scan (10):** header TMS 1,0,0; L shift bits as above; trailer TMS 1,0. Total L+5 bits.
- **Scan length L:** CMD_LEN; 0 or >32 means L=32.
- **RTI wait (11):** CMD_LEN bits with TMS 0. CMD_LEN=0 means no TCK.
- **TDI:** during shift bit i, TDI = latched DATA[i]. TDI is 0 in all other bits.
- **RSP_DATA:** bit i = TDO sampled at shift bit i. Bits ≥ L are 0. RSP_DATA is 0 for ops 00 and 11.
- **Response:** DONE pulses RSP_VALID for one cycle and updates RSP_DATA. RSP_DATA then holds until the next response.
- **Return to IDLE:** IDLE and CMD_READY=1 are reached in the same cycle as RSP_VALID, so back-to-back accepts are possible.

## Timing

- **Bit period:** 2*DIV cycles.
  - Cycles 0..DIV-1: TCK=0; TMS/TDI update at the start of cycle 0 (TCK falling phase).
  - Cycles DIV..2*DIV-1: TCK=1.
  - TDO is sampled on the CLK edge that raises TCK.
- **TCK idle level:** TCK is 0 when no bit is in progress.
- **Command timing:** the accept cycle is cycle 0. The first bit starts at cycle 1. For N bits, RSP_VALID is high in cycle N*2*DIV+1.
- **RTI wait with CMD_LEN=0:** RSP_VALID is high in cycle 1.
- **Startup:** with DIV=2, CMD_READY rises 6*4 = 24 cycles after the first non-reset cycle plus 1.

## Test plan

- **Startup:** RST high 3 cycles, then low → TRSTN=1 next cycle; 6 TCK pulses with TMS 1,1,1,1,1,0; CMD_READY high at cycle 25; no RSP_VALID.
- **IR scan:** OP=01, LEN=4, DATA=0x9; TAP model IR capture = 0b0001 → 10 TCK; TMS 1,1,0,0,0,0,0,1,1,0; TDI during shift = 1,0,0,1; RSP_DATA=0x00000001.
- **DR scan through bypass:** OP=10, LEN=0 (treated as 32), DATA=0xDEADBEEF; TAP model in BYPASS (capture 0, 1-bit delay) → 37 TCK; RSP_DATA=0xBD5B7DDE.
- **Latency:** DIV=2, OP=10, LEN=8 → RSP_VALID exactly in cycle 53 after the accept cycle. CMD_VALID held high during BUSY is not accepted. A second command is accepted in the RSP_VALID cycle.
- **RTI wait:** OP=11, LEN=0 → RSP_VALID in cycle 1, no TCK, RSP_DATA=0. OP=11, LEN=5 → 5 TCK with TMS=0, RSP_VALID in cycle 21.
- **Reset mid-scan:** RST asserted during a DR shift bit → next cycle all outputs at reset values, no RSP_VALID. After release, AUTO_TLR runs, then a new IR scan completes correctly.
